// File: rtl/dot_operand_packer_pkg.sv
// Shared widths and lane-slice helpers for the DotProduct operand interface.
// The macros slice lane i out of a flat packed vector.
`define DOT_PIX_LANE(v, i) v[(i)*dot_operand_packer_pkg::PIX_W +: dot_operand_packer_pkg::PIX_W]
`define DOT_WT_LANE(v, i)  v[(i)*dot_operand_packer_pkg::WT_W +: dot_operand_packer_pkg::WT_W]

package dot_operand_packer_pkg;
    localparam int N_LANES   = 10;
    localparam int PIX_W     = 19;
    localparam int WT_W      = 9;
    localparam int LANE_W    = 4;
    localparam int VEC_PIX_W = N_LANES * PIX_W;   // 190
    localparam int VEC_WT_W  = N_LANES * WT_W;    // 90
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);
endpackage

// File: rtl/dot_weight_regfile.sv
// Ten-entry weight register file; out-of-range addresses are ignored.
// All lanes are exposed at once so the top can snapshot them in one edge.
module dot_weight_regfile
    import dot_operand_packer_pkg::*;
(
    input  logic                 clk,
    input  logic                 GlobalReset,
    input  logic                 i_we,
    input  logic [LANE_W-1:0]    i_addr,
    input  logic [WT_W-1:0]      i_data,
    output logic [VEC_WT_W-1:0]  o_bus
);
    logic [WT_W-1:0] r_wt [N_LANES];

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            for (int i = 0; i < N_LANES; i++) r_wt[i] <= '0;
        end else if (i_we && (i_addr <= LAST_LANE)) begin
            r_wt[i_addr] <= i_data;
        end
    end

    always_comb begin
        o_bus = '0;
        for (int i = 0; i < N_LANES; i++) `DOT_WT_LANE(o_bus, i) = r_wt[i];
    end
endmodule

// File: rtl/dot_operand_packer.sv
// Collects serial pixels into a lane vector and hands vector plus weight
// snapshot to DotProduct over valid/ready, one pixel per clock sustained.
module dot_operand_packer
    import dot_operand_packer_pkg::*;
(
    input  logic                  clk,
    input  logic                  GlobalReset,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [PIX_W-1:0]      pix_data,
    input  logic                  pix_first,
    input  logic                  wt_we,
    input  logic [LANE_W-1:0]     wt_addr,
    input  logic [WT_W-1:0]       wt_data,
    output logic [VEC_PIX_W-1:0]  Pixels,
    output logic [VEC_WT_W-1:0]   Weights,
    output logic                  vec_valid,
    input  logic                  vec_ready
);
    logic [PIX_W-1:0]     r_fill [N_LANES];
    logic [LANE_W-1:0]    r_lane;
    logic                 r_full;
    logic [VEC_PIX_W-1:0] r_pixels;
    logic [VEC_WT_W-1:0]  r_weights;
    logic                 r_vec_valid;

    logic [VEC_WT_W-1:0]  w_wt_bus;
    logic [VEC_PIX_W-1:0] w_fill_flat;
    logic                 w_slot_free;
    logic                 w_transfer;
    logic                 w_accept;

    dot_weight_regfile u_wt (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .i_we        (wt_we),
        .i_addr      (wt_addr),
        .i_data      (wt_data),
        .o_bus       (w_wt_bus)
    );

    always_comb begin
        w_fill_flat = '0;
        for (int i = 0; i < N_LANES; i++) `DOT_PIX_LANE(w_fill_flat, i) = r_fill[i];
    end

    // A full buffer frees itself on the same edge it drains, so the stream never bubbles.
    assign w_slot_free = !r_vec_valid || vec_ready;
    assign w_transfer  = r_full && w_slot_free;
    assign pix_ready   = !GlobalReset && (!r_full || w_slot_free);
    assign w_accept    = pix_valid && pix_ready;

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            for (int i = 0; i < N_LANES; i++) r_fill[i] <= '0;
            r_lane      <= '0;
            r_full      <= 1'b0;
            r_pixels    <= '0;
            r_weights   <= '0;
            r_vec_valid <= 1'b0;
        end else begin
            if (w_transfer) begin
                r_pixels    <= w_fill_flat;
                r_weights   <= w_wt_bus;
                r_vec_valid <= 1'b1;
                r_full      <= 1'b0;
            end else if (r_vec_valid && vec_ready) begin
                r_vec_valid <= 1'b0;
            end

            // An accept while full always coincides with a transfer, so full can
            // never be set and cleared on the same edge.
            if (w_accept) begin
                if (pix_first) begin
                    r_fill[0] <= pix_data;
                    r_lane    <= LANE_W'(1);
                end else begin
                    r_fill[r_lane] <= pix_data;
                    if (r_lane == LAST_LANE) begin
                        r_lane <= '0;
                        r_full <= 1'b1;
                    end else begin
                        r_lane <= r_lane + 1'b1;
                    end
                end
            end
        end
    end

    assign Pixels    = r_pixels;
    assign Weights   = r_weights;
    assign vec_valid = r_vec_valid;
endmodule

// File: tb/tb_dot_operand_packer.sv
// Directed bench for dot_operand_packer: reset, latency, streaming, backpressure,
// pix_first discard, weight-write race and mid-vector reset.
module tb_dot_operand_packer;
    logic         clk;
    logic         GlobalReset;
    logic         pix_valid;
    logic         pix_ready;
    logic [18:0]  pix_data;
    logic         pix_first;
    logic         wt_we;
    logic [3:0]   wt_addr;
    logic [8:0]   wt_data;
    logic [189:0] Pixels;
    logic [89:0]  Weights;
    logic         vec_valid;
    logic         vec_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    int vv_cycles;
    logic acc_now;

    int           hs_edge [$];
    logic [189:0] hs_pix  [$];
    logic [89:0]  hs_wt   [$];

    dot_operand_packer dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_first   (pix_first),
        .wt_we       (wt_we),
        .wt_addr     (wt_addr),
        .wt_data     (wt_data),
        .Pixels      (Pixels),
        .Weights     (Weights),
        .vec_valid   (vec_valid),
        .vec_ready   (vec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [189:0] pvec(input int base);
        logic [189:0] v;
        v = '0;
        for (int i = 0; i < 10; i++) v[i*19 +: 19] = 19'(base + i);
        return v;
    endfunction

    function automatic logic [89:0] wvec(input bit lane3_ones, input bit zero);
        logic [89:0] v;
        v = '0;
        for (int i = 0; i < 10; i++) v[i*9 +: 9] = zero ? 9'd0 : 9'(i);
        if (lane3_ones) v[3*9 +: 9] = 9'h1FF;
        return v;
    endfunction

    // Inputs are set by the caller just after an edge; this records what the
    // coming edge will do, then advances to 1ns past that edge.
    task automatic step();
        #1;
        acc_now = pix_valid && pix_ready;
        if (vec_valid && vec_ready) begin
            hs_edge.push_back(edge_n + 1);
            hs_pix.push_back(Pixels);
            hs_wt.push_back(Weights);
        end
        if (vec_valid) vv_cycles++;
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic clear_log();
        hs_edge.delete();
        hs_pix.delete();
        hs_wt.delete();
        vv_cycles = 0;
    endtask

    task automatic idle_inputs();
        pix_valid = 1'b0;
        pix_data  = '0;
        pix_first = 1'b0;
        wt_we     = 1'b0;
        wt_addr   = '0;
        wt_data   = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        vec_ready   = 1'b0;
        GlobalReset = 1'b1;
        repeat (3) step();
        n_checks++;
        if (pix_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_pix_ready: got %b want 0", pix_ready);
        end
        n_checks++;
        if (vec_valid !== 1'b0 || Pixels !== '0 || Weights !== '0) begin
            n_fail++; $display("FAIL reset_outputs: vec_valid=%b Pixels=%h Weights=%h want all 0", vec_valid, Pixels, Weights);
        end
        GlobalReset = 1'b0;
        #1;
        n_checks++;
        if (pix_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_pix_ready: got %b want 1", pix_ready);
        end
    endtask

    task automatic test_basic();
        int n, guard, first_edge;
        longint dot;
        logic [189:0] p;
        logic [89:0]  w;
        clear_log();
        vec_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wt_we = 1'b1; wt_addr = 4'(i); wt_data = 9'(i);
            step();
        end
        idle_inputs();
        vv_cycles = 0;
        n = 0; guard = 0; first_edge = -1;
        while (n < 10 && guard < 40) begin
            pix_valid = 1'b1; pix_data = 19'h20000; pix_first = (n == 0);
            step();
            if (acc_now) begin
                if (n == 0) first_edge = edge_n;
                n++;
            end
            guard++;
        end
        idle_inputs();
        repeat (15) step();
        n_checks++;
        if (n != 10) begin
            n_fail++; $display("FAIL basic_accept_count: got %0d want 10", n);
        end
        n_checks++;
        if (hs_edge.size() != 1) begin
            n_fail++; $display("FAIL basic_vec_count: got %0d want 1", hs_edge.size());
        end else begin
            n_checks++;
            if (hs_edge[0] != first_edge + 11) begin
                n_fail++; $display("FAIL basic_latency: handshake edge %0d want %0d", hs_edge[0], first_edge + 11);
            end
            p = hs_pix[0];
            w = hs_wt[0];
            n_checks++;
            if (p !== {10{19'h20000}}) begin
                n_fail++; $display("FAIL basic_pixels: got %h want %h", p, {10{19'h20000}});
            end
            n_checks++;
            if (w !== wvec(1'b0, 1'b0)) begin
                n_fail++; $display("FAIL basic_weights: got %h want %h", w, wvec(1'b0, 1'b0));
            end
            dot = 0;
            for (int i = 0; i < 10; i++) dot += longint'(p[i*19 +: 19]) * longint'(w[i*9 +: 9]);
            n_checks++;
            if (dot != 64'd90 * 64'd65536) begin
                n_fail++; $display("FAIL basic_dot_value: got %0d want %0d (90.0 in 16 frac bits)", dot, 90 * 65536);
            end
        end
        n_checks++;
        if (vv_cycles != 1) begin
            n_fail++; $display("FAIL basic_valid_width: vec_valid high %0d cycles want 1", vv_cycles);
        end
    endtask

    task automatic test_back_to_back();
        int n, guard, drops;
        clear_log();
        vec_ready = 1'b1;
        n = 0; guard = 0; drops = 0;
        while (n < 30 && guard < 60) begin
            pix_valid = 1'b1; pix_data = 19'(100 + n); pix_first = (n % 10 == 0);
            step();
            if (acc_now) n++; else drops++;
            guard++;
        end
        idle_inputs();
        repeat (15) step();
        n_checks++;
        if (n != 30 || drops != 0) begin
            n_fail++; $display("FAIL b2b_pix_ready: accepted %0d stalls %0d want 30 and 0", n, drops);
        end
        n_checks++;
        if (hs_edge.size() != 3) begin
            n_fail++; $display("FAIL b2b_vec_count: got %0d want 3", hs_edge.size());
        end else begin
            n_checks++;
            if (hs_edge[1] - hs_edge[0] != 10 || hs_edge[2] - hs_edge[1] != 10) begin
                n_fail++; $display("FAIL b2b_spacing: edges %0d %0d %0d want spacing 10", hs_edge[0], hs_edge[1], hs_edge[2]);
            end
            for (int v = 0; v < 3; v++) begin
                n_checks++;
                if (hs_pix[v] !== pvec(100 + 10 * v)) begin
                    n_fail++; $display("FAIL b2b_pixels_%0d: got %h want %h", v, hs_pix[v], pvec(100 + 10 * v));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n, guard, hold_err;
        clear_log();
        vec_ready = 1'b0;
        n = 0; guard = 0; hold_err = 0;
        while (vec_valid !== 1'b1 && guard < 30) begin
            pix_valid = (n < 30); pix_data = 19'(200 + n); pix_first = (n % 10 == 0);
            step();
            if (acc_now) n++;
            guard++;
        end
        n_checks++;
        if (vec_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_first_vec_timeout: vec_valid=%b want 1", vec_valid);
        end
        for (int c = 0; c < 25; c++) begin
            pix_valid = (n < 30); pix_data = 19'(200 + n); pix_first = (n % 10 == 0);
            step();
            if (acc_now) n++;
            if (vec_valid !== 1'b1 || Pixels !== pvec(200)) hold_err++;
        end
        n_checks++;
        if (hold_err != 0) begin
            n_fail++; $display("FAIL bp_hold: %0d cycles changed, got %h want %h", hold_err, Pixels, pvec(200));
        end
        #1;
        n_checks++;
        if (pix_ready !== 1'b0 || n != 20) begin
            n_fail++; $display("FAIL bp_stall: pix_ready=%b accepted=%0d want 0 and 20", pix_ready, n);
        end
        vec_ready = 1'b1;
        pix_valid = (n < 30); pix_data = 19'(200 + n); pix_first = (n % 10 == 0);
        step();
        if (acc_now) n++;
        n_checks++;
        if (vec_valid !== 1'b1 || Pixels !== pvec(210) || n != 21) begin
            n_fail++; $display("FAIL bp_release: vec_valid=%b Pixels=%h accepted=%0d want 1 %h 21", vec_valid, Pixels, n, pvec(210));
        end
        guard = 0;
        while ((n < 30 || vec_valid === 1'b1) && guard < 60) begin
            pix_valid = (n < 30); pix_data = 19'(200 + n); pix_first = (n % 10 == 0);
            step();
            if (acc_now) n++;
            guard++;
        end
        idle_inputs();
        repeat (5) step();
        n_checks++;
        if (hs_pix.size() != 3) begin
            n_fail++; $display("FAIL bp_vec_count: got %0d want 3", hs_pix.size());
        end else begin
            for (int v = 0; v < 3; v++) begin
                n_checks++;
                if (hs_pix[v] !== pvec(200 + 10 * v)) begin
                    n_fail++; $display("FAIL bp_pixels_%0d: got %h want %h", v, hs_pix[v], pvec(200 + 10 * v));
                end
            end
        end
    endtask

    task automatic test_first();
        int n, guard;
        logic [189:0] exp_v;
        clear_log();
        vec_ready = 1'b1;
        n = 0; guard = 0;
        while (n < 14 && guard < 40) begin
            pix_valid = 1'b1;
            pix_first = (n == 0 || n == 4);
            pix_data  = (n < 4) ? 19'(500 + n) : (n == 4) ? 19'h10000 : 19'(600 + n - 5);
            step();
            if (acc_now) n++;
            guard++;
        end
        idle_inputs();
        repeat (15) step();
        exp_v = '0;
        exp_v[18:0] = 19'h10000;
        for (int i = 1; i < 10; i++) exp_v[i*19 +: 19] = 19'(600 + i - 1);
        n_checks++;
        if (hs_pix.size() != 1) begin
            n_fail++; $display("FAIL first_vec_count: got %0d want 1", hs_pix.size());
        end else begin
            n_checks++;
            if (hs_pix[0] !== exp_v) begin
                n_fail++; $display("FAIL first_pixels: got %h want %h", hs_pix[0], exp_v);
            end
        end
    endtask

    task automatic test_weight_race();
        int n, guard;
        bit did_bad, did_race;
        clear_log();
        vec_ready = 1'b1;
        n = 0; guard = 0; did_bad = 0; did_race = 0;
        while (n < 20 && guard < 50) begin
            pix_valid = 1'b1; pix_data = 19'(700 + n); pix_first = (n % 10 == 0);
            wt_we = 1'b0;
            if (n == 5 && !did_bad) begin
                wt_we = 1'b1; wt_addr = 4'd12; wt_data = 9'h055; did_bad = 1;
            end else if (n == 10 && !did_race) begin
                wt_we = 1'b1; wt_addr = 4'd3; wt_data = 9'h1FF; did_race = 1;
            end
            step();
            if (acc_now) n++;
            guard++;
        end
        idle_inputs();
        repeat (15) step();
        n_checks++;
        if (hs_wt.size() != 2) begin
            n_fail++; $display("FAIL wt_vec_count: got %0d want 2", hs_wt.size());
        end else begin
            n_checks++;
            if (hs_wt[0] !== wvec(1'b0, 1'b0)) begin
                n_fail++; $display("FAIL wt_old_snapshot: got %h want %h", hs_wt[0], wvec(1'b0, 1'b0));
            end
            n_checks++;
            if (hs_wt[1] !== wvec(1'b1, 1'b0)) begin
                n_fail++; $display("FAIL wt_new_snapshot: got %h want %h", hs_wt[1], wvec(1'b1, 1'b0));
            end
            n_checks++;
            if (hs_pix[1] !== pvec(710)) begin
                n_fail++; $display("FAIL wt_pixels: got %h want %h", hs_pix[1], pvec(710));
            end
        end
    endtask

    task automatic test_mid_reset();
        int n, guard;
        clear_log();
        vec_ready = 1'b1;
        n = 0; guard = 0;
        while (n < 6 && guard < 20) begin
            pix_valid = 1'b1; pix_data = 19'(800 + n); pix_first = (n == 0);
            step();
            if (acc_now) n++;
            guard++;
        end
        GlobalReset = 1'b1;
        pix_valid = 1'b1; pix_data = 19'h7FFFF; pix_first = 1'b0;
        step();
        n_checks++;
        if (acc_now !== 1'b0) begin
            n_fail++; $display("FAIL midrst_accept: pixel accepted during reset, got %b want 0", acc_now);
        end
        n_checks++;
        if (vec_valid !== 1'b0 || Pixels !== '0 || Weights !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: vec_valid=%b Pixels=%h Weights=%h want all 0", vec_valid, Pixels, Weights);
        end
        GlobalReset = 1'b0;
        clear_log();
        n = 0; guard = 0;
        while (n < 10 && guard < 30) begin
            pix_valid = 1'b1; pix_data = 19'(900 + n); pix_first = 1'b0;
            step();
            if (acc_now) n++;
            guard++;
        end
        idle_inputs();
        repeat (15) step();
        n_checks++;
        if (hs_pix.size() != 1) begin
            n_fail++; $display("FAIL midrst_vec_count: got %0d want 1", hs_pix.size());
        end else begin
            n_checks++;
            if (hs_pix[0] !== pvec(900) || hs_wt[0] !== wvec(1'b0, 1'b1)) begin
                n_fail++; $display("FAIL midrst_vector: Pixels=%h Weights=%h want %h and 0", hs_pix[0], hs_wt[0], pvec(900));
            end
        end
    endtask

    initial begin
        idle_inputs();
        GlobalReset = 1'b1;
        vec_ready   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_first();
        test_weight_race();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
